// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the play-area stages.
package game_pkg;

    localparam int unsigned OBST_ID_W   = 3;
    localparam int unsigned FRAME_CNT_W = 10;
    localparam int unsigned ROUND_W     = 8;
    localparam int unsigned LFSR_W      = 8;

    // Play-area line constants shared with the drawing stages
    localparam int unsigned PLAY_X_MIN = 112;
    localparam int unsigned PLAY_X_MAX = 912;
    localparam int unsigned PLAY_Y_MIN = 184;
    localparam int unsigned PLAY_Y_MAX = 584;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WARMUP   = 3'd1,
        ST_ATTACK   = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_OVER     = 3'd4
    } state_e;

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control/status bundle between the scheduler and the VGA-side stages.
interface obstacle_scheduler_if;
    import game_pkg::*;

    logic                   vblnk_in;
    logic                   play_selected;
    logic                   menu_on;
    logic                   game_over;
    logic                   obstacle_done;
    logic                   game_active;
    logic                   obstacle_active;
    logic                   obstacle_start;
    logic [OBST_ID_W-1:0]   obstacle_id;
    logic [ROUND_W-1:0]     round_cnt;
    logic [FRAME_CNT_W-1:0] frames_left;

    modport master (
        output vblnk_in, play_selected, menu_on, game_over, obstacle_done,
        input  game_active, obstacle_active, obstacle_start, obstacle_id,
               round_cnt, frames_left
    );

    modport slave (
        input  vblnk_in, play_selected, menu_on, game_over, obstacle_done,
        output game_active, obstacle_active, obstacle_start, obstacle_id,
               round_cnt, frames_left
    );

endinterface

// File: rtl/frame_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); exposes its low OUT_W bits.
module frame_lfsr #(
    parameter logic [7:0]  SEED  = 8'hA5,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    output logic [OUT_W-1:0] value
);

    logic [7:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (shift_en) begin
            state_q <= {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
        end
    end

    assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-flow controller: warm-up, then alternating attack/cooldown phases
// paced by vblank, with pseudo-random non-repeating pattern selection.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_OBSTACLES   = 4,
    parameter int unsigned WARMUP_FRAMES   = 120,
    parameter int unsigned ATTACK_FRAMES   = 300,
    parameter int unsigned COOLDOWN_FRAMES = 60,
    parameter int unsigned COOLDOWN_STEP   = 5,
    parameter int unsigned MIN_COOLDOWN    = 20,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic                 pclk,
    input  logic                 rst,
    obstacle_scheduler_if.slave  bus
);

    localparam logic [FRAME_CNT_W-1:0] FL_ONE = FRAME_CNT_W'(1);

    state_e                 state;
    logic                   vblnk_q;
    logic                   tick;
    logic                   in_game;
    logic [OBST_ID_W-1:0]   lfsr_low;
    logic [OBST_ID_W-1:0]   prev_id;
    logic [FRAME_CNT_W-1:0] cooldown_len;
    logic [FRAME_CNT_W-1:0] cooldown_next;
    logic [3:0]             raw_ext;
    logic [3:0]             raw_inc;
    logic [OBST_ID_W-1:0]   sel_id;

    assign tick    = bus.vblnk_in & ~vblnk_q;
    assign in_game = (state == ST_WARMUP) || (state == ST_ATTACK) || (state == ST_COOLDOWN);

    frame_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (OBST_ID_W)
    ) u_lfsr (
        .clk      (pclk),
        .rst      (rst),
        .shift_en (tick & in_game),
        .value    (lfsr_low)
    );

    // Fold the raw LFSR bits into range and step past the previous pattern
    always_comb begin
        raw_ext = {1'b0, lfsr_low};
        if (raw_ext >= 4'(NUM_OBSTACLES)) begin
            raw_ext = raw_ext - 4'(NUM_OBSTACLES);
        end
        raw_inc = raw_ext + 4'd1;
        if ((raw_ext[OBST_ID_W-1:0] == prev_id) && (bus.round_cnt != '0)) begin
            raw_ext = (raw_inc == 4'(NUM_OBSTACLES)) ? 4'd0 : raw_inc;
        end
        sel_id = raw_ext[OBST_ID_W-1:0];
    end

    assign cooldown_next = (cooldown_len >= FRAME_CNT_W'(MIN_COOLDOWN + COOLDOWN_STEP))
                         ? cooldown_len - FRAME_CNT_W'(COOLDOWN_STEP)
                         : FRAME_CNT_W'(MIN_COOLDOWN);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state               <= ST_IDLE;
            vblnk_q             <= 1'b0;
            prev_id             <= '0;
            cooldown_len        <= FRAME_CNT_W'(COOLDOWN_FRAMES);
            bus.game_active     <= 1'b0;
            bus.obstacle_active <= 1'b0;
            bus.obstacle_start  <= 1'b0;
            bus.obstacle_id     <= '0;
            bus.round_cnt       <= '0;
            bus.frames_left     <= '0;
        end else begin
            vblnk_q            <= bus.vblnk_in;
            bus.obstacle_start <= 1'b0;
            if (bus.menu_on) begin
                state               <= ST_IDLE;
                bus.game_active     <= 1'b0;
                bus.obstacle_active <= 1'b0;
                bus.frames_left     <= '0;
            end else if (bus.game_over && in_game) begin
                state               <= ST_OVER;
                bus.game_active     <= 1'b0;
                bus.obstacle_active <= 1'b0;
                bus.frames_left     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.play_selected) begin
                            state           <= ST_WARMUP;
                            bus.game_active <= 1'b1;
                            bus.frames_left <= FRAME_CNT_W'(WARMUP_FRAMES);
                            bus.round_cnt   <= '0;
                            cooldown_len    <= FRAME_CNT_W'(COOLDOWN_FRAMES);
                        end
                    end
                    ST_WARMUP, ST_COOLDOWN: begin
                        if (tick) begin
                            if (bus.frames_left == FL_ONE) begin
                                state               <= ST_ATTACK;
                                bus.obstacle_active <= 1'b1;
                                bus.obstacle_start  <= 1'b1;
                                bus.obstacle_id     <= sel_id;
                                prev_id             <= sel_id;
                                bus.frames_left     <= FRAME_CNT_W'(ATTACK_FRAMES);
                            end else if (bus.frames_left != '0) begin
                                bus.frames_left <= bus.frames_left - FL_ONE;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        // Early finish and timeout collapse into a single exit
                        if (bus.obstacle_done || (tick && (bus.frames_left == FL_ONE))) begin
                            state               <= ST_COOLDOWN;
                            bus.obstacle_active <= 1'b0;
                            bus.round_cnt       <= (bus.round_cnt == '1) ? bus.round_cnt
                                                                         : bus.round_cnt + ROUND_W'(1);
                            cooldown_len        <= cooldown_next;
                            bus.frames_left     <= cooldown_next;
                        end else if (tick && (bus.frames_left != '0)) begin
                            bus.frames_left <= bus.frames_left - FL_ONE;
                        end
                    end
                    ST_OVER: begin
                        state <= ST_OVER;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench: cycle model + id scoreboard plus directed game scenarios.
module tb_obstacle_scheduler;

    localparam int NUM  = 4;
    localparam int WARM = 3;
    localparam int ATT  = 5;
    localparam int COOL = 4;
    localparam int STEP = 1;
    localparam int MINC = 2;
    localparam int BUDGET = 1000;

    typedef struct {
        int         st;      // 0 idle, 1 warmup, 2 attack, 3 cooldown, 4 over
        logic [7:0] lfsr;
        int         fl;
        int         rounds;
        int         cool;
        int         prev;
        int         id;
        bit         start;
        bit         vq;
    } model_t;

    logic   pclk;
    logic   rst;
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     lock_en  = 0;
    int     last_id  = 0;
    int     exp_q[$];
    model_t m;

    obstacle_scheduler_if bus ();

    obstacle_scheduler #(
        .NUM_OBSTACLES   (NUM),
        .WARMUP_FRAMES   (WARM),
        .ATTACK_FRAMES   (ATT),
        .COOLDOWN_FRAMES (COOL),
        .COOLDOWN_STEP   (STEP),
        .MIN_COOLDOWN    (MINC),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        bus.vblnk_in = 1'b0;
        forever begin
            repeat (20) @(posedge pclk);
            #1 bus.vblnk_in = ~bus.vblnk_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int pick(input logic [7:0] l, input int prev, input int rounds);
        int r;
        r = int'(l[2:0]);
        if (r >= NUM) r -= NUM;
        if (r == prev && rounds != 0) r = (r + 1 == NUM) ? 0 : r + 1;
        return r;
    endfunction

    function automatic model_t step(input model_t c, input bit r, input bit v, input bit ps,
                                    input bit mo, input bit go, input bit od);
        model_t n;
        bit tick, live;
        n = c;
        if (r) begin
            n.st = 0; n.lfsr = 8'hA5; n.fl = 0; n.rounds = 0; n.cool = COOL;
            n.prev = 0; n.id = 0; n.start = 0; n.vq = 0;
            return n;
        end
        tick    = v && !c.vq;
        live    = (c.st >= 1 && c.st <= 3);
        n.vq    = v;
        n.start = 0;
        if (tick && live) n.lfsr = lfsr_next(c.lfsr);
        if (mo) begin
            n.st = 0; n.fl = 0;
        end else if (go && live) begin
            n.st = 4; n.fl = 0;
        end else if (c.st == 0) begin
            if (ps) begin n.st = 1; n.fl = WARM; n.rounds = 0; n.cool = COOL; end
        end else if (c.st == 1 || c.st == 3) begin
            if (tick && c.fl == 1) begin
                n.st = 2; n.fl = ATT; n.start = 1;
                n.id = pick(c.lfsr, c.prev, c.rounds); n.prev = n.id;
            end else if (tick && c.fl > 0) n.fl = c.fl - 1;
        end else if (c.st == 2) begin
            if (od || (tick && c.fl == 1)) begin
                n.st = 3;
                n.rounds = (c.rounds < 255) ? c.rounds + 1 : 255;
                n.cool = (c.cool - STEP > MINC) ? c.cool - STEP : MINC;
                n.fl = n.cool;
            end else if (tick && c.fl > 0) n.fl = c.fl - 1;
        end
        return n;
    endfunction

    always @(posedge pclk)
        m <= step(m, rst, bus.vblnk_in, bus.play_selected, bus.menu_on, bus.game_over,
                  bus.obstacle_done);

    // Lockstep comparison and id scoreboard, sampled mid-cycle
    always @(negedge pclk) begin
        if (lock_en) begin
            if (m.start) exp_q.push_back(m.id);
            check("lockstep",
                  32'({bus.game_active, bus.obstacle_active, bus.obstacle_start,
                       bus.obstacle_id, bus.round_cnt, bus.frames_left}),
                  32'({1'((m.st >= 1) && (m.st <= 3)), 1'(m.st == 2), 1'(m.start),
                       3'(m.id), 8'(m.rounds), 10'(m.fl)}));
            if (bus.obstacle_start === 1'b1) begin
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("sb_id", 32'(bus.obstacle_id), 32'(exp_q.pop_front()));
                check("id_range", 32'(bus.obstacle_id < 3'd4), 32'd1);
                if (bus.round_cnt != 8'd0)
                    check("id_repeat", 32'(int'(bus.obstacle_id) != last_id), 32'd1);
                last_id = int'(bus.obstacle_id);
            end
        end
    end

    task automatic wait_start();
        int n = 0;
        do begin @(negedge pclk); n++; end
        while (bus.obstacle_start !== 1'b1 && n < BUDGET);
        check("start_seen", 32'(bus.obstacle_start), 32'd1);
    endtask

    task automatic wait_attack_end();
        int n = 0;
        do begin @(negedge pclk); n++; end
        while (bus.obstacle_active !== 1'b0 && n < BUDGET);
        check("attack_end_seen", 32'(bus.obstacle_active), 32'd0);
    endtask

    task automatic wait_frames(input int val);
        int n = 0;
        do begin @(negedge pclk); n++; end
        while (int'(bus.frames_left) != val && n < BUDGET);
        check("frames_reached", 32'(bus.frames_left), 32'(val));
    endtask

    initial begin
        rst = 1'b1;
        bus.play_selected = 1'b0;
        bus.menu_on       = 1'b0;
        bus.game_over     = 1'b0;
        bus.obstacle_done = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_outs", 32'({bus.game_active, bus.obstacle_active, bus.obstacle_start,
                                 bus.obstacle_id, bus.round_cnt, bus.frames_left}), 32'd0);
        lock_en = 1;
        rst = 1'b0;

        // Start: warm-up of 3 frames, then first attack
        bus.play_selected = 1'b1;
        @(negedge pclk);
        bus.play_selected = 1'b0;
        check("warmup_active", 32'(bus.game_active), 32'd1);
        check("warmup_frames", 32'(bus.frames_left), 32'd3);
        wait_start();
        check("attack_active", 32'(bus.obstacle_active), 32'd1);
        check("attack_frames", 32'(bus.frames_left), 32'd5);
        check("first_id", 32'(bus.obstacle_id), 32'd1);
        @(negedge pclk);
        check("start_one_cycle", 32'(bus.obstacle_start), 32'd0);

        // Timeouts: cooldown 3, then 2, then floored at 2
        wait_attack_end();
        check("cool1_frames", 32'(bus.frames_left), 32'd3);
        check("cool1_round", 32'(bus.round_cnt), 32'd1);
        wait_start();
        wait_attack_end();
        check("cool2_frames", 32'(bus.frames_left), 32'd2);
        wait_start();
        wait_attack_end();
        check("cool3_floor", 32'(bus.frames_left), 32'd2);
        check("cool3_round", 32'(bus.round_cnt), 32'd3);

        // Early finish on the second attack frame
        wait_start();
        wait_frames(4);
        bus.obstacle_done = 1'b1;
        @(negedge pclk);
        bus.obstacle_done = 1'b0;
        check("done_exit", 32'(bus.obstacle_active), 32'd0);
        check("done_round", 32'(bus.round_cnt), 32'd4);
        repeat (2) @(negedge pclk);
        bus.obstacle_done = 1'b1;
        @(negedge pclk);
        bus.obstacle_done = 1'b0;
        check("done_in_cool_round", 32'(bus.round_cnt), 32'd4);
        check("done_in_cool_active", 32'(bus.obstacle_active), 32'd0);

        for (int r = 0; r < 20; r++) begin
            wait_start();
            wait_attack_end();
        end
        check("rounds_after_loop", 32'(bus.round_cnt), 32'd24);

        // game_over beats obstacle_done in the same cycle
        wait_start();
        bus.game_over     = 1'b1;
        bus.obstacle_done = 1'b1;
        @(negedge pclk);
        bus.obstacle_done = 1'b0;
        bus.game_over     = 1'b0;
        check("over_inactive", 32'(bus.game_active), 32'd0);
        check("over_round_held", 32'(bus.round_cnt), 32'd24);
        check("over_frames", 32'(bus.frames_left), 32'd0);
        bus.play_selected = 1'b1;
        repeat (3) @(negedge pclk);
        bus.play_selected = 1'b0;
        check("over_ignores_play", 32'(bus.game_active), 32'd0);
        bus.menu_on = 1'b1;
        @(negedge pclk);
        bus.menu_on = 1'b0;
        check("menu_round_kept", 32'(bus.round_cnt), 32'd24);
        bus.play_selected = 1'b1;
        @(negedge pclk);
        bus.play_selected = 1'b0;
        check("restart_active", 32'(bus.game_active), 32'd1);
        check("restart_round", 32'(bus.round_cnt), 32'd0);

        // Reset together with menu_on in the middle of a cooldown
        wait_start();
        wait_attack_end();
        @(negedge pclk);
        rst = 1'b1;
        bus.menu_on = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        bus.menu_on = 1'b0;
        check("rst_outs", 32'({bus.game_active, bus.obstacle_active, bus.obstacle_start,
                               bus.obstacle_id, bus.round_cnt, bus.frames_left}), 32'd0);
        bus.play_selected = 1'b1;
        @(negedge pclk);
        bus.play_selected = 1'b0;
        wait_start();
        check("rst_seed_id", 32'(bus.obstacle_id), 32'd1);
        wait_attack_end();
        check("rst_cool_restored", 32'(bus.frames_left), 32'd3);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
